// File: rtl/tri_pkg.sv
// Shared types for the triangle scan path: coordinate widths, the scanner state
// encoding and small unsigned min/max helpers used by the bounding-box logic.
package tri_pkg;

    localparam int CW    = 11;
    localparam int CNT_W = 23;

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        BBOX,
        ISSUE,
        WAIT,
        DONE
    } scan_state_t;

    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tri_bbox.sv
// Combinational bounding box of three unsigned vertices.
module tri_bbox
    import tri_pkg::*;
(
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    input  logic [CW-1:0] x2,
    input  logic [CW-1:0] y2,
    input  logic [CW-1:0] x3,
    input  logic [CW-1:0] y3,
    output logic [CW-1:0] xmin,
    output logic [CW-1:0] xmax,
    output logic [CW-1:0] ymin,
    output logic [CW-1:0] ymax
);

    assign xmin = coord_min(coord_min(x1, x2), x3);
    assign xmax = coord_max(coord_max(x1, x2), x3);
    assign ymin = coord_min(coord_min(y1, y2), y3);
    assign ymax = coord_max(coord_max(y1, y2), y3);

endmodule

// File: rtl/tri_raster_scanner.sv
// Walks a triangle's bounding box in raster order, one point-in-triangle request at a
// time, and streams out the inside pixels. TRI_SCAN_DEGEN_CHECK_EN adds a zero-area skip.
module tri_raster_scanner
    import tri_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    p1x,
    input  logic [CW-1:0]    p1y,
    input  logic [CW-1:0]    p2x,
    input  logic [CW-1:0]    p2y,
    input  logic [CW-1:0]    p3x,
    input  logic [CW-1:0]    p3y,
    output logic             busy,
    output logic             done,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [CW-1:0]    req_x,
    output logic [CW-1:0]    req_y,
    input  logic             res_valid,
    input  logic             res_inside,
    output logic             pix_valid,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic [CNT_W-1:0] inside_count
`ifdef TRI_SCAN_DEGEN_CHECK_EN
    ,
    output logic             degen
`endif
);

    scan_state_t state, state_nxt;

    logic [CW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [CW-1:0] xmin, xmax, ymin, ymax;
    logic [CW-1:0] cur_x, cur_y;
    logic          last_point;
    logic          area_zero;

    tri_bbox u_bbox (
        .x1   (v1x),
        .y1   (v1y),
        .x2   (v2x),
        .y2   (v2y),
        .x3   (v3x),
        .y3   (v3y),
        .xmin (xmin),
        .xmax (xmax),
        .ymin (ymin),
        .ymax (ymax)
    );

`ifdef TRI_SCAN_DEGEN_CHECK_EN
    localparam int AW = 2 * CW + 2;

    logic signed [AW-1:0] sx1, sy1, sx2, sy2, sx3, sy3, area;

    assign sx1  = $signed({{(AW-CW){1'b0}}, v1x});
    assign sy1  = $signed({{(AW-CW){1'b0}}, v1y});
    assign sx2  = $signed({{(AW-CW){1'b0}}, v2x});
    assign sy2  = $signed({{(AW-CW){1'b0}}, v2y});
    assign sx3  = $signed({{(AW-CW){1'b0}}, v3x});
    assign sy3  = $signed({{(AW-CW){1'b0}}, v3y});
    assign area = sx1 * (sy2 - sy3) + sx2 * (sy3 - sy1) + sx3 * (sy1 - sy2);
    assign area_zero = (area == '0);
`else
    assign area_zero = 1'b0;
`endif

    // Equality against the box edges, never an increment-and-overflow test, so a
    // box touching 2^CW-1 terminates without wrapping.
    assign last_point = (cur_x == xmax) && (cur_y == ymax);

    // NOTE: always_comb assigns every output a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BBOX;
            BBOX:    state_nxt = area_zero ? DONE : ISSUE;
            ISSUE:   if (req_ready) state_nxt = WAIT;
            WAIT:    if (res_valid) state_nxt = last_point ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: vertex registers have no reset; they are only read after a start loads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            v1x <= p1x;
            v1y <= p1y;
            v2x <= p2x;
            v2y <= p2y;
            v3x <= p3x;
            v3y <= p3y;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_x        <= '0;
            cur_y        <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            inside_count <= '0;
`ifdef TRI_SCAN_DEGEN_CHECK_EN
            degen        <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        inside_count <= '0;
`ifdef TRI_SCAN_DEGEN_CHECK_EN
                        degen        <= 1'b0;
`endif
                    end
                end
                BBOX: begin
                    cur_x <= xmin;
                    cur_y <= ymin;
`ifdef TRI_SCAN_DEGEN_CHECK_EN
                    degen <= area_zero;
`endif
                end
                WAIT: begin
                    if (res_valid) begin
                        if (res_inside) begin
                            pix_valid    <= 1'b1;
                            pix_x        <= cur_x;
                            pix_y        <= cur_y;
                            inside_count <= inside_count + CNT_W'(1);
                        end
                        if (cur_x != xmax) begin
                            cur_x <= cur_x + CW'(1);
                        end else if (cur_y != ymax) begin
                            cur_x <= xmin;
                            cur_y <= cur_y + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == BBOX) || (state == ISSUE) || (state == WAIT);
    assign done      = (state == DONE);
    assign req_valid = (state == ISSUE);
    assign req_x     = cur_x;
    assign req_y     = cur_y;

endmodule

// File: tb/tb_tri_raster_scanner.sv
// Self-checking bench: a behavioural tester stub (inclusive edge functions, random
// ready/latency) plus a raster-order reference model of requests and inside pixels.
module tb_tri_raster_scanner;
    import tri_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n, start;
    logic [CW-1:0]    p1x, p1y, p2x, p2y, p3x, p3y;
    logic             busy, done, req_valid, req_ready;
    logic [CW-1:0]    req_x, req_y;
    logic             res_valid, res_inside;
    logic             pix_valid;
    logic [CW-1:0]    pix_x, pix_y;
    logic [CNT_W-1:0] inside_count;
`ifdef TRI_SCAN_DEGEN_CHECK_EN
    logic             degen;
`endif

    always #5 clk = ~clk;

    tri_raster_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .p1x          (p1x),
        .p1y          (p1y),
        .p2x          (p2x),
        .p2y          (p2y),
        .p3x          (p3x),
        .p3y          (p3y),
        .busy         (busy),
        .done         (done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .res_valid    (res_valid),
        .res_inside   (res_inside),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .inside_count (inside_count)
`ifdef TRI_SCAN_DEGEN_CHECK_EN
        ,
        .degen        (degen)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int tv[6];
    int exp_rx[$], exp_ry[$], exp_px[$], exp_py[$];
    int exp_count;
    bit exp_degen;

    function automatic int edge_fn(int ax, int ay, int bx, int by, int px, int py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic bit in_tri(int px, int py);
        int e0, e1, e2;
        e0 = edge_fn(tv[0], tv[1], tv[2], tv[3], px, py);
        e1 = edge_fn(tv[2], tv[3], tv[4], tv[5], px, py);
        e2 = edge_fn(tv[4], tv[5], tv[0], tv[1], px, py);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    function automatic bit zero_area();
        return (tv[0] * (tv[3] - tv[5]) + tv[2] * (tv[5] - tv[1]) + tv[4] * (tv[1] - tv[3])) == 0;
    endfunction

    task automatic build_model(input int x1, input int y1, input int x2, input int y2,
                               input int x3, input int y3);
        int xmn, xmx, ymn, ymx;
        tv = '{x1, y1, x2, y2, x3, y3};
        exp_rx.delete(); exp_ry.delete(); exp_px.delete(); exp_py.delete();
        exp_count = 0;
        exp_degen = 1'b0;
`ifdef TRI_SCAN_DEGEN_CHECK_EN
        if (zero_area()) begin
            exp_degen = 1'b1;
            return;
        end
`endif
        xmn = (x1 < x2) ? x1 : x2;  xmn = (xmn < x3) ? xmn : x3;
        xmx = (x1 > x2) ? x1 : x2;  xmx = (xmx > x3) ? xmx : x3;
        ymn = (y1 < y2) ? y1 : y2;  ymn = (ymn < y3) ? ymn : y3;
        ymx = (y1 > y2) ? y1 : y2;  ymx = (ymx > y3) ? ymx : y3;
        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                exp_rx.push_back(x);
                exp_ry.push_back(y);
                if (in_tri(x, y)) begin
                    exp_px.push_back(x);
                    exp_py.push_back(y);
                    exp_count++;
                end
            end
        end
    endtask

    // ------------- tester stub + compare process -------------
    bit monitor_on      = 1'b0;
    bit abort_req       = 1'b0;
    bit force_ready_low = 1'b0;
    bit spurious_res    = 1'b0;
    int done_cnt        = 0;
    int hs_cnt          = 0;

    initial begin
        int res_delay;
        bit res_in;
        res_delay  = -1;
        res_in     = 1'b0;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        res_inside = 1'b0;
        forever begin
            @(negedge clk);
            if (abort_req) begin
                exp_rx.delete(); exp_ry.delete(); exp_px.delete(); exp_py.delete();
                res_delay  = -1;
                req_ready  = 1'b0;
                res_valid  = 1'b0;
                res_inside = 1'b0;
                continue;
            end
            if (monitor_on) begin
                if (req_valid) begin
                    if (exp_rx.size() == 0) check("req_unexpected", req_valid, 0);
                    else begin
                        check("req_x", req_x, exp_rx[0]);
                        check("req_y", req_y, exp_ry[0]);
                    end
                end
                if (pix_valid) begin
                    if (exp_px.size() == 0) check("pix_unexpected", pix_valid, 0);
                    else begin
                        check("pix_x", pix_x, exp_px[0]);
                        check("pix_y", pix_y, exp_py[0]);
                        void'(exp_px.pop_front());
                        void'(exp_py.pop_front());
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy", busy, 0);
                    check("done_reqs_left", exp_rx.size(), 0);
                    check("done_pix_left", exp_px.size(), 0);
                    check("done_inside_count", inside_count, exp_count);
`ifdef TRI_SCAN_DEGEN_CHECK_EN
                    check("done_degen", degen, exp_degen);
`endif
                end
            end
            res_valid  = 1'b0;
            res_inside = 1'b0;
            if (res_delay == 0) begin
                res_valid  = 1'b1;
                res_inside = res_in;
                res_delay  = -1;
            end else if (res_delay > 0) begin
                res_delay--;
            end
            if (spurious_res) begin
                res_valid  = 1'b1;
                res_inside = 1'b1;
            end
            req_ready = force_ready_low ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (req_valid && req_ready) begin
                res_in    = in_tri(int'(req_x), int'(req_y));
                res_delay = $urandom_range(0, 3);
                hs_cnt++;
                if (exp_rx.size() > 0) begin
                    void'(exp_rx.pop_front());
                    void'(exp_ry.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input int x1, input int y1, input int x2, input int y2,
                               input int x3, input int y3);
        @(negedge clk);
        p1x = CW'(x1); p1y = CW'(y1); p2x = CW'(x2); p2y = CW'(y2); p3x = CW'(x3); p3y = CW'(y3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        // Scramble the vertex inputs to prove they were latched.
        p1x = CW'($urandom); p1y = CW'($urandom); p2x = CW'($urandom);
        p2y = CW'($urandom); p3x = CW'($urandom); p3y = CW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("scan_completed", done_cnt - d0, 1);
        repeat (4) @(posedge clk);
        check("single_done_pulse", done_cnt - d0, 1);
        @(negedge clk);
        check("count_held", inside_count, exp_count);
        check("idle_not_busy", busy, 0);
    endtask

    task automatic run_scan(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3);
        int d0;
        build_model(x1, y1, x2, y2, x3, y3);
        d0 = done_cnt;
        pulse_start(x1, y1, x2, y2, x3, y3);
        wait_done(d0, exp_rx.size() * 12 + 50);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0, h0, prev_count, n, x0, y0;
        rst_n = 1'b0;
        start = 1'b0;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_req_xy", {req_x, req_y}, 0);
        check("rst_pix_xy", {pix_x, pix_y}, 0);
        check("rst_count", inside_count, 0);
`ifdef TRI_SCAN_DEGEN_CHECK_EN
        check("rst_degen", degen, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        monitor_on = 1'b1;

        // Test 1: reference triangle, model pinned with hand-derived values.
        build_model(1, 6, 4, 14, 17, 5);
        check("t1_model_points", exp_rx.size(), 170);
        check("t1_model_first", {exp_rx[0], exp_ry[0]}, {32'd1, 32'd5});
        check("t1_model_last", {exp_rx[169], exp_ry[169]}, {32'd17, 32'd14});
        check("t1_model_vertex_in", in_tri(1, 6), 1);
        check("t1_model_corner_out", in_tri(17, 14), 0);
        check("t1_model_below_out", in_tri(1, 5), 0);
        run_scan(1, 6, 4, 14, 17, 5);

        // Test 5: box at the top of the coordinate range.
        build_model(2047, 2047, 2046, 2047, 2047, 2046);
        check("t5_model_points", exp_rx.size(), 4);
        check("t5_model_inside", exp_count, 3);
        run_scan(2047, 2047, 2046, 2047, 2047, 2046);

        // Test 2: all vertices equal.
        build_model(7, 8, 7, 8, 7, 8);
`ifdef TRI_SCAN_DEGEN_CHECK_EN
        check("t2_model_points", exp_rx.size(), 0);
`else
        check("t2_model_points", exp_rx.size(), 1);
`endif
        run_scan(7, 8, 7, 8, 7, 8);

        // Test 4a: spurious results while idle.
        prev_count = exp_count;
        @(posedge clk);
        spurious_res = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_idle_no_pix", pix_valid, 0);
        check("t4_idle_count", inside_count, prev_count);
        @(posedge clk);
        spurious_res = 1'b0;

        // Test 3 + 4b: stall in ISSUE, spurious results and a stray start meanwhile.
        build_model(3, 3, 6, 3, 3, 6);
        @(posedge clk);
        force_ready_low = 1'b1;
        d0 = done_cnt;
        pulse_start(3, 3, 6, 3, 3, 6);
        n = 0;
        while (!req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_req_seen", req_valid, 1);
        @(posedge clk);
        spurious_res = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                p1x = 20; p1y = 20; p2x = 30; p2y = 20; p3x = 20; p3y = 30;
                start = 1'b1;
            end
            if (i == 3) start = 1'b0;
            check("t3_req_valid_held", req_valid, 1);
            check("t3_req_xy_held", {req_x, req_y}, {11'd3, 11'd3});
            check("t3_no_count", inside_count, 0);
            check("t3_no_pix", pix_valid, 0);
        end
        @(posedge clk);
        spurious_res    = 1'b0;
        force_ready_low = 1'b0;
        wait_done(d0, exp_rx.size() * 12 + 50);

        // Randomized triangles, some near the top edge of the range.
        for (int t = 0; t < 4; t++) begin
            x0 = (t % 2 == 0) ? $urandom_range(0, 200) : $urandom_range(2020, 2027);
            y0 = (t % 2 == 0) ? $urandom_range(0, 200) : $urandom_range(2020, 2027);
            run_scan(x0 + $urandom_range(0, 20), y0 + $urandom_range(0, 20),
                     x0 + $urandom_range(0, 20), y0 + $urandom_range(0, 20),
                     x0 + $urandom_range(0, 20), y0 + $urandom_range(0, 20));
        end

        // Test 6: reset after five requests, then a clean rescan.
        build_model(1, 6, 4, 14, 17, 5);
        h0 = hs_cnt;
        d0 = done_cnt;
        pulse_start(1, 6, 4, 14, 17, 5);
        n = 0;
        while (hs_cnt - h0 < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("t6_five_requests", hs_cnt - h0, 5);
        abort_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_req_valid", req_valid, 0);
        check("t6_pix_valid", pix_valid, 0);
        check("t6_req_xy", {req_x, req_y}, 0);
        check("t6_pix_xy", {pix_x, pix_y}, 0);
        check("t6_count", inside_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
            check("t6_stays_idle", busy, 0);
        end
        check("t6_no_done_pulse", done_cnt - d0, 0);
        @(posedge clk);
        abort_req = 1'b0;
        run_scan(1, 6, 4, 14, 17, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
